// File: rtl/ttm_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ttm_pkg
// Brief  : Shared types and constants for the TTM4 program memory.
//          Holds the loader state encoding, the default instruction field
//          widths and the field offsets within a packed instruction word
//          ([IM | LR | SR | OP], IM at bit 0, OP at the top).
// Rev    : 1.0  initial parametrised program memory
//------------------------------------------------------------------------------
package ttm_pkg;

   // Loader state machine encoding
   typedef enum logic [1:0] {
      L_IDLE  = 2'd0,
      L_BYTE  = 2'd1,
      L_WRITE = 2'd2,
      L_FULL  = 2'd3
   } ld_state_e;

   // Default geometry
   localparam int ADDR_W_DEF = 8;
   localparam int IM_W_DEF   = 4;
   localparam int LR_W_DEF   = 3;
   localparam int SR_W_DEF   = 3;
   localparam int OP_W_DEF   = 5;

   // Field offsets at the default widths
   localparam int IM_LSB = 0;
   localparam int LR_LSB = IM_LSB + IM_W_DEF;
   localparam int SR_LSB = LR_LSB + LR_W_DEF;
   localparam int OP_LSB = SR_LSB + SR_W_DEF;

   // Number of loader bytes needed to carry a word of the given width
   function automatic int nbytes_for(input int word_w);
      return (word_w + 7) / 8;
   endfunction

endpackage : ttm_pkg
`default_nettype wire

// File: rtl/ttm_spram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ttm_spram
// Brief  : Generic single-port synchronous RAM with one write port and a
//          registered read. The read register resets to zero and only
//          updates on a read enable, so it holds the last read word.
// Ports  : clk_i    clock
//          rst_i    synchronous active-high reset (read register only)
//          we_i     write enable
//          re_i     read enable
//          addr_i   shared read/write address
//          wdata_i  write data
//          rdata_o  registered read data
// Rev    : 1.0  initial version
//------------------------------------------------------------------------------
module ttm_spram #(
   parameter int WIDTH  = 15,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Array is deliberately not reset so program contents survive a reset
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : ttm_spram
`default_nettype wire

// File: rtl/ttm_prog_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ttm_prog_mem
// Brief  : Parametrised TTM4 program memory. A byte-stream loader (valid /
//          ready, LSB byte first) assembles instruction words and writes them
//          at an auto-incrementing pointer; in run mode a registered fetch
//          port returns the unpacked IM/LR/SR/OP fields one cycle after a
//          request.
// Ports  : clk_i        clock
//          rst_i        synchronous active-high reset
//          mode_i       0 = run (fetch), 1 = load
//          ld_valid_i   loader byte valid
//          ld_data_i    loader byte
//          ld_ready_o   loader accepts a byte this cycle
//          ld_full_o    all words written in the current session
//          ld_count_o   words committed in the current session
//          fe_req_i     fetch request
//          fe_addr_i    fetch address
//          fe_valid_o   fetch data valid (1-cycle pulse)
//          fe_im_o/fe_lr_o/fe_sr_o/fe_op_o  fetched fields
// Rev    : 1.0  replaces the fixed two-SRAM 8-bit-address store
//------------------------------------------------------------------------------
module ttm_prog_mem
   import ttm_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IM_W   = IM_W_DEF,
   parameter int LR_W   = LR_W_DEF,
   parameter int SR_W   = SR_W_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mode_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   output logic              ld_ready_o,
   output logic              ld_full_o,
   output logic [ADDR_W:0]   ld_count_o,
   input  logic              fe_req_i,
   input  logic [ADDR_W-1:0] fe_addr_i,
   output logic              fe_valid_o,
   output logic [IM_W-1:0]   fe_im_o,
   output logic [LR_W-1:0]   fe_lr_o,
   output logic [SR_W-1:0]   fe_sr_o,
   output logic [OP_W-1:0]   fe_op_o
);

   localparam int WORD_W = IM_W + LR_W + SR_W + OP_W;
   localparam int NBYTES = nbytes_for(WORD_W);
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   // Field offsets for this instance's widths
   localparam int IM_OFF = 0;
   localparam int LR_OFF = IM_OFF + IM_W;
   localparam int SR_OFF = LR_OFF + LR_W;
   localparam int OP_OFF = SR_OFF + SR_W;

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] asm_q;
   logic [ADDR_W:0]   count_q;
   logic              full_q;
   logic              fe_valid_q;

   // Control strobes decoded from the state
   logic              ld_ready;
   logic              byte_acc;
   logic              word_wr;
   logic              sess_start;
   logic              abort;
   logic              fetch_en;
   logic              last_byte;
   logic              ptr_last;

   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_rdata;

   assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
   assign ptr_last  = &ptr_q;

   //---------------------------------------------------------------------------
   // Loader FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= L_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //---------------------------------------------------------------------------
   // Loader FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         L_IDLE: begin
            if (mode_i) state_d = L_BYTE;
         end
         L_BYTE: begin
            // Leaving load mode drops any partially assembled word
            if (!mode_i)                       state_d = L_IDLE;
            else if (ld_valid_i && last_byte)  state_d = L_WRITE;
         end
         L_WRITE: begin
            // The write itself always completes; only the successor changes
            if (!mode_i)       state_d = L_IDLE;
            else if (ptr_last) state_d = L_FULL;
            else               state_d = L_BYTE;
         end
         L_FULL: begin
            if (!mode_i) state_d = L_IDLE;
         end
         default: state_d = L_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Loader FSM: outputs and datapath strobes
   //---------------------------------------------------------------------------
   always_comb begin
      ld_ready   = 1'b0;
      byte_acc   = 1'b0;
      word_wr    = 1'b0;
      sess_start = 1'b0;
      abort      = 1'b0;
      fetch_en   = 1'b0;
      case (state_q)
         L_IDLE: begin
            sess_start = mode_i;
            fetch_en   = !mode_i && fe_req_i;
         end
         L_BYTE: begin
            ld_ready = 1'b1;
            byte_acc = mode_i && ld_valid_i;
            abort    = !mode_i;
         end
         L_WRITE: begin
            word_wr = 1'b1;
         end
         default: ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Pointer, byte index, word count and full flag
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (sess_start) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
         end
         if (byte_acc && !last_byte) begin
            idx_q <= idx_q + 1'b1;
         end
         if (abort) begin
            idx_q <= '0;
         end
         if (word_wr) begin
            idx_q   <= '0;
            count_q <= count_q + 1'b1;
            // Pointer parks on the last word; full stays set until a new session
            if (ptr_last) full_q <= 1'b1;
            else          ptr_q  <= ptr_q + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Assembly register: each word bit is taken from the byte that carries it,
   // so bits of the last byte beyond WORD_W are never stored.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (byte_acc) begin
         for (int i = 0; i < WORD_W; i++) begin
            if (idx_q == IDX_W'(i / 8)) begin
               asm_q[i] <= ld_data_i[i % 8];
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Fetch valid strobe
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fe_valid_q <= 1'b0;
      end else begin
         fe_valid_q <= fetch_en;
      end
   end

   // Writes and fetches are mutually exclusive, so one address port suffices
   assign ram_addr = word_wr ? ptr_q : fe_addr_i;

   ttm_spram #(
      .WIDTH  (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (word_wr),
      .re_i    (fetch_en),
      .addr_i  (ram_addr),
      .wdata_i (asm_q),
      .rdata_o (ram_rdata)
   );

   assign ld_ready_o = ld_ready;
   assign ld_full_o  = full_q;
   assign ld_count_o = count_q;
   assign fe_valid_o = fe_valid_q;
   assign fe_im_o    = ram_rdata[IM_OFF +: IM_W];
   assign fe_lr_o    = ram_rdata[LR_OFF +: LR_W];
   assign fe_sr_o    = ram_rdata[SR_OFF +: SR_W];
   assign fe_op_o    = ram_rdata[OP_OFF +: OP_W];

endmodule : ttm_prog_mem
`default_nettype wire

// File: tb/tb_ttm_prog_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_ttm_prog_mem
// Brief  : Directed testbench for ttm_prog_mem at default parameters.
// Rev    : 1.0  initial version
//------------------------------------------------------------------------------
module tb_ttm_prog_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       ld_full;
   logic [8:0] ld_count;
   logic       fe_req;
   logic [7:0] fe_addr;
   logic       fe_valid;
   logic [3:0] fe_im;
   logic [2:0] fe_lr;
   logic [2:0] fe_sr;
   logic [4:0] fe_op;
   logic [14:0] fe_word;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign fe_word = {fe_op, fe_sr, fe_lr, fe_im};

   ttm_prog_mem dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .mode_i     (mode),
      .ld_valid_i (ld_valid),
      .ld_data_i  (ld_data),
      .ld_ready_o (ld_ready),
      .ld_full_o  (ld_full),
      .ld_count_o (ld_count),
      .fe_req_i   (fe_req),
      .fe_addr_i  (fe_addr),
      .fe_valid_o (fe_valid),
      .fe_im_o    (fe_im),
      .fe_lr_o    (fe_lr),
      .fe_sr_o    (fe_sr),
      .fe_op_o    (fe_op)
   );

   // Word stored at address i by the full-memory load
   function automatic logic [15:0] full_word(input int i);
      return 16'((i * 97 + 3) & 32'h7FFF);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and wait (bounded) until it is accepted
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      ld_valid = 1'b1;
      ld_data  = b;
      while (ld_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      n_tests++;
      if (ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_byte_timeout: ld_ready=%b after %0d cycles, required 1", ld_ready, waited);
      end else begin
         tick();
      end
      ld_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
      fe_req = 1'b0; fe_addr = 8'h00;
      repeat (3) tick();
      n_tests++;
      if ({ld_ready, ld_full, ld_count, fe_valid} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready=%b full=%b count=%0d valid=%b, required all 0", ld_ready, ld_full, ld_count, fe_valid);
      end
      n_tests++;
      if (fe_word !== 15'h0000) begin
         n_fail++;
         $display("FAIL reset_fields: got %h, required 0000", fe_word);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_fetch();
      mode = 1'b1;
      tick();
      send_byte(8'h5A);
      send_byte(8'h23);
      n_tests++;
      if (ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL lf_write_ready: got %b, required 0", ld_ready);
      end
      tick();
      n_tests++;
      if (ld_count !== 9'd1) begin
         n_fail++;
         $display("FAIL lf_count: got %0d, required 1", ld_count);
      end
      mode = 1'b0;
      tick();
      fe_req = 1'b1; fe_addr = 8'd0;
      tick();
      fe_req = 1'b0;
      n_tests++;
      if ({fe_valid, fe_im, fe_lr, fe_sr, fe_op} !== {1'b1, 4'hA, 3'd5, 3'd6, 5'd8}) begin
         n_fail++;
         $display("FAIL lf_fetch: valid=%b im=%h lr=%0d sr=%0d op=%0d, required 1 a 5 6 8", fe_valid, fe_im, fe_lr, fe_sr, fe_op);
      end
      tick();
      n_tests++;
      if (fe_valid !== 1'b0 || fe_word !== 15'h235A) begin
         n_fail++;
         $display("FAIL lf_hold: valid=%b word=%h, required 0 235a", fe_valid, fe_word);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] words [3];
      logic [15:0] w;
      words[0] = 16'h1234; words[1] = 16'hCABC; words[2] = 16'h0F0F;
      mode = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         w = words[k];
         for (int b = 0; b < 2; b++) begin
            repeat ($urandom_range(0, 3)) begin
               n_tests++;
               if (ld_ready !== 1'b1) begin
                  n_fail++;
                  $display("FAIL bp_gap_ready: word %0d got %b, required 1", k, ld_ready);
               end
               tick();
            end
            send_byte(w[8*b +: 8]);
         end
         n_tests++;
         if (ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_write_ready: word %0d got %b, required 0", k, ld_ready);
         end
         tick();
      end
      n_tests++;
      if (ld_count !== 9'd3) begin
         n_fail++;
         $display("FAIL bp_count: got %0d, required 3", ld_count);
      end
      mode = 1'b0;
      tick();
      // Back-to-back fetches, one word per cycle
      fe_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fe_addr = 8'(k);
         tick();
         w = words[k];
         n_tests++;
         if (fe_valid !== 1'b1 || fe_word !== w[14:0]) begin
            n_fail++;
            $display("FAIL bp_fetch%0d: valid=%b word=%h, required 1 %h", k, fe_valid, fe_word, w[14:0]);
         end
      end
      fe_req = 1'b0;
      tick();
      n_tests++;
      if (fe_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_valid_drop: got %b, required 0", fe_valid);
      end
   endtask

   task automatic test_full();
      logic [15:0] w;
      mode = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         send_word(full_word(i));
      end
      tick();
      n_tests++;
      if (ld_full !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 9'd256) begin
         n_fail++;
         $display("FAIL full_state: full=%b ready=%b count=%0d, required 1 0 256", ld_full, ld_ready, ld_count);
      end
      ld_valid = 1'b1; ld_data = 8'hFF;
      repeat (2) begin
         tick();
         n_tests++;
         if (ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_extra_ready: got %b, required 0", ld_ready);
         end
      end
      ld_valid = 1'b0;
      n_tests++;
      if (ld_count !== 9'd256) begin
         n_fail++;
         $display("FAIL full_extra_count: got %0d, required 256", ld_count);
      end
      mode = 1'b0;
      tick();
      n_tests++;
      if (ld_full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_held_idle: got %b, required 1", ld_full);
      end
      fe_req = 1'b1; fe_addr = 8'd0;
      tick();
      w = full_word(0);
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== w[14:0]) begin
         n_fail++;
         $display("FAIL full_mem0: valid=%b word=%h, required 1 %h", fe_valid, fe_word, w[14:0]);
      end
      fe_addr = 8'd255;
      tick();
      w = full_word(255);
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== w[14:0]) begin
         n_fail++;
         $display("FAIL full_mem255: valid=%b word=%h, required 1 %h", fe_valid, fe_word, w[14:0]);
      end
      fe_req = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      logic [15:0] w;
      mode = 1'b1;
      tick();
      n_tests++;
      if (ld_full !== 1'b0 || ld_count !== 9'd0) begin
         n_fail++;
         $display("FAIL abort_session_clear: full=%b count=%0d, required 0 0", ld_full, ld_count);
      end
      send_word(16'h1111);
      tick();
      send_byte(8'h77);
      mode = 1'b0;
      tick();
      n_tests++;
      if (ld_count !== 9'd1) begin
         n_fail++;
         $display("FAIL abort_count: got %0d, required 1", ld_count);
      end
      fe_req = 1'b1; fe_addr = 8'd0;
      tick();
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== 15'h1111) begin
         n_fail++;
         $display("FAIL abort_mem0: valid=%b word=%h, required 1 1111", fe_valid, fe_word);
      end
      fe_addr = 8'd1;
      tick();
      w = full_word(1);
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== w[14:0]) begin
         n_fail++;
         $display("FAIL abort_mem1: valid=%b word=%h, required 1 %h", fe_valid, fe_word, w[14:0]);
      end
      fe_req = 1'b0;
      tick();
   endtask

   task automatic test_fetch_blocked();
      logic [15:0] w;
      w = full_word(1);
      mode = 1'b1;
      fe_req = 1'b1; fe_addr = 8'd0;
      repeat (3) begin
         tick();
         n_tests++;
         if (fe_valid !== 1'b0 || fe_word !== w[14:0]) begin
            n_fail++;
            $display("FAIL blocked_load: valid=%b word=%h, required 0 %h", fe_valid, fe_word, w[14:0]);
         end
      end
      // Run mode requested but the loader has not yet returned to idle
      mode = 1'b0;
      tick();
      fe_req = 1'b0;
      n_tests++;
      if (fe_valid !== 1'b0 || fe_word !== w[14:0]) begin
         n_fail++;
         $display("FAIL blocked_not_idle: valid=%b word=%h, required 0 %h", fe_valid, fe_word, w[14:0]);
      end
      tick();
   endtask

   task automatic test_reset_midload();
      logic [15:0] w;
      mode = 1'b1;
      tick();
      send_byte(8'h99);
      rst = 1'b1;
      tick();
      n_tests++;
      if ({ld_ready, ld_full, ld_count, fe_valid} !== 12'h000 || fe_word !== 15'h0000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: ready=%b full=%b count=%0d valid=%b word=%h, required all 0", ld_ready, ld_full, ld_count, fe_valid, fe_word);
      end
      rst = 1'b0;
      tick();
      send_word(16'h3C2A);
      tick();
      n_tests++;
      if (ld_count !== 9'd1) begin
         n_fail++;
         $display("FAIL rst_mid_count: got %0d, required 1", ld_count);
      end
      mode = 1'b0;
      tick();
      fe_req = 1'b1; fe_addr = 8'd0;
      tick();
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== 15'h3C2A) begin
         n_fail++;
         $display("FAIL rst_mid_mem0: valid=%b word=%h, required 1 3c2a", fe_valid, fe_word);
      end
      fe_addr = 8'd1;
      tick();
      w = full_word(1);
      n_tests++;
      if (fe_valid !== 1'b1 || fe_word !== w[14:0]) begin
         n_fail++;
         $display("FAIL rst_mid_mem1: valid=%b word=%h, required 1 %h", fe_valid, fe_word, w[14:0]);
      end
      fe_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load_fetch();
      test_backpressure();
      test_full();
      test_abort();
      test_fetch_blocked();
      test_reset_midload();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ttm_prog_mem
`default_nettype wire

// File: doc/ttm_prog_mem.md
Name: ttm_prog_mem

Overview:
- Parametrised program memory for the TTM4 emulator. It replaces the fixed two-SRAM, 8-bit-address instruction store.
- Holds instruction words made of IM/LR/SR/OP fields with configurable field widths and depth.
- Adds a byte-stream loader with a valid/ready handshake and auto-incrementing write pointer.
- Read port is a registered fetch port with a valid strobe, used by the CPU core in run mode.

Parameters:
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words.
- IM_W, 4: immediate field width.
- LR_W, 3: load-register field width.
- SR_W, 3: store-register field width.
- OP_W, 5: opcode field width.
- Derived localparams:
  - WORD_W = IM_W+LR_W+SR_W+OP_W (15 at defaults).
  - NBYTES = ceil(WORD_W/8) (2 at defaults).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- MODE  in  1  0 = run (fetch enabled), 1 = load.
- LD_VALID  in  1  loader byte valid.
- LD_DATA  in  8  loader byte, least-significant byte of each word first.
- LD_READY  out  1  loader can accept a byte this cycle.
- LD_FULL  out  1  all DEPTH words written in the current load session.
- LD_COUNT  out  ADDR_W+1  words committed in the current load session.
- FE_REQ  in  1  fetch request.
- FE_ADDR  in  ADDR_W  fetch address.
- FE_VALID  out  1  fetch data valid, 1-cycle pulse.
- FE_IM  out  IM_W  fetched immediate.
- FE_LR  out  LR_W  fetched LR field.
- FE_SR  out  SR_W  fetched SR field.
- FE_OP  out  OP_W  fetched opcode.

Behaviour:
- Word packing, LSB first: [IM | LR | SR | OP]. IM occupies bits [IM_W-1:0]; OP occupies the top bits.
- Loader bytes concatenate byte0 = bits [7:0], byte1 = bits [15:8], and so on. Bits above WORD_W-1 in the last byte are discarded.
- Reset:
  - All outputs are 0, the FSM goes to L_IDLE, and the pointer, byte index and LD_COUNT are cleared.
  - Memory contents are NOT cleared.
- Loader FSM states: L_IDLE, L_BYTE, L_WRITE, L_FULL.
- L_IDLE:
  - LD_READY=0.
  - When MODE=1: clear the pointer, byte index and LD_COUNT, clear LD_FULL, and go to L_BYTE.
- L_BYTE:
  - LD_READY=1.
  - A byte is accepted when LD_VALID&&LD_READY and goes into the assembly register at the current byte index.
  - If the index was NBYTES-1, go to L_WRITE; otherwise increment the index.
  - Gaps in LD_VALID simply hold the state.
- L_WRITE (one cycle):
  - LD_READY=0.
  - Write the assembled word to mem[ptr], LD_COUNT++, clear the byte index.
  - If ptr==DEPTH-1, go to L_FULL; otherwise ptr++ and return to L_BYTE.
- L_FULL:
  - LD_FULL=1, LD_READY=0; further bytes are ignored.
  - LD_FULL stays high until MODE=0; then go to L_IDLE, with LD_FULL held until the next load session starts.
- MODE falling mid-word (any state except L_WRITE):
  - Discard the partial word, go to L_IDLE, and keep LD_COUNT.
  - If MODE falls during L_WRITE, the write still completes, then the FSM goes to L_IDLE.
- Fetch:
  - Active only when MODE=0 and the FSM is in L_IDLE.
  - On FE_REQ, read mem[FE_ADDR]. FE_VALID=1 the next cycle with the fields registered.
  - The fields hold their value until the next fetch.
  - Back-to-back FE_REQ gives full throughput: one word per cycle at 1-cycle latency.
  - FE_REQ while MODE=1 or the FSM is not in L_IDLE is ignored: FE_VALID=0 and the fields are unchanged.
- Read and write never occur in the same cycle, because the modes are exclusive. This gives a single-port RAM inference: one write port, one registered read.
- RST asserted mid-load aborts the session immediately. Words already written remain in memory.

Decomposition:
- Package ttm_pkg holds:
  - loader state enum (L_IDLE, L_BYTE, L_WRITE, L_FULL);
  - default field-width constants;
  - field offset constants IM_LSB, LR_LSB, SR_LSB and OP_LSB, derived from the widths.
- One sub-module, ttm_spram: a generic single-port synchronous RAM (WIDTH, ADDR_W) with write enable and a registered read.
- Loader FSM, assembly register and field unpacking stay in ttm_prog_mem.

Test Plan:
- Load and fetch at defaults:
  - Stimulus: MODE=1, bytes 0x5A,0x23, MODE=0, then FE_REQ with FE_ADDR=0.
  - Response: LD_COUNT=1; next cycle FE_VALID=1, FE_IM=0xA, FE_LR=5, FE_SR=6, FE_OP=8.
- Backpressure:
  - Stimulus: load 3 words with random LD_VALID gaps.
  - Response: LD_READY=0 exactly in each L_WRITE cycle; fetching addresses 0..2 returns the three words in order; LD_COUNT=3.
- Full:
  - Stimulus: stream 512 bytes (256 words), then 2 extra bytes.
  - Response: LD_FULL=1 and LD_READY=0 after the 256th write; LD_COUNT=256; the extras are ignored; mem[0] is not overwritten.
- Abort mid-word:
  - Stimulus: after 1 word, send 1 byte, then MODE=0.
  - Response: LD_COUNT stays 1; mem[1] is unchanged; a fetch at address 1 returns the old contents.
- Fetch blocked in load:
  - Stimulus: FE_REQ=1 while MODE=1.
  - Response: FE_VALID remains 0 and the FE_* fields are unchanged.
- Reset mid-load:
  - Stimulus: assert RST while in L_BYTE after byte0.
  - Response: next cycle all outputs are 0 and the FSM is in L_IDLE; a new session starts from address 0.
